// File: rtl/spi_pkg.sv
// Shared types and constants for the configurable SPI master and its clock generator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_t;

  // SPI mode is {cpol, cpha}
  typedef logic [1:0] spi_mode_t;
  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_CS  = 4;
  localparam int DEF_CLK_DIV = 4;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing for the SPI master: half-period divider plus SCLK edge counter.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic xfer,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES);

  logic [7:0]    div_q, div_d;
  logic [EW-1:0] edge_q, edge_d;

  // tick marks the final cycle of each CLK_DIV window; in XFER it is also an SCLK edge
  always_comb begin
    tick       = en && (div_q == 8'(CLK_DIV - 1));
    lead_edge  = xfer && tick && !edge_q[0];
    trail_edge = xfer && tick && edge_q[0];
    last_edge  = xfer && tick && (edge_q == EW'(EDGES - 1));

    div_d = (!en || tick) ? '0 : div_q + 8'd1;

    edge_d = edge_q;
    if (!xfer) begin
      edge_d = '0;
    end else if (tick) begin
      edge_d = last_edge ? '0 : edge_q + EW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      edge_q <= '0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: one word per request with per-transfer mode, chip select
// and bit order; all outputs come straight from flops.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_CS  = DEF_NUM_CS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_enable,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [cs_width(NUM_CS)-1:0] cs_sel,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic                        lsb_first,
  input  logic                        miso,
  output logic                        sclk,
  output logic                        mosi,
  output logic [NUM_CS-1:0]           cs_n,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        busy,
  output logic                        done
);

  localparam int CS_W  = cs_width(NUM_CS);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CS_W:0] NUM_CS_V = (CS_W + 1)'(NUM_CS);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [CS_W-1:0]   sel_q, sel_d;
  spi_mode_t         mode_q, mode_d;
  logic              lsb_q, lsb_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              start, active_d, gen_en, gen_xfer;
  logic              tick, lead_edge, trail_edge, last_edge;

  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx, input logic lsb);
    return lsb ? idx : IDX_W'(DATA_W - 1) - idx;
  endfunction

  assign gen_en   = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
  assign gen_xfer = (state_q == XFER);

  spi_clk_gen #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (gen_en),
    .xfer      (gen_xfer),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .last_edge (last_edge)
  );

  always_comb begin
    start   = (state_q == IDLE) && tx_enable && ({1'b0, cs_sel} < NUM_CS_V);
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = XFER;
      XFER:    if (last_edge) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_d   = tx_q;
    sel_d  = sel_q;
    mode_d = mode_q;
    lsb_d  = lsb_q;
    if (start) begin
      tx_d   = tx_data;
      sel_d  = cs_sel;
      mode_d = {cpol, cpha};
      lsb_d  = lsb_first;
    end

    // cpha=0 presents bit 0 before the first edge; cpha=1 launches it on edge 1
    tx_idx_d   = tx_idx_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    mosi_d     = mosi_q;
    if (start) begin
      tx_idx_d   = '0;
      rx_idx_d   = '0;
      rx_shift_d = '0;
      mosi_d     = cpha ? 1'b0 : tx_data[bit_pos('0, lsb_first)];
    end else if (lead_edge) begin
      if (mode_q[0]) begin
        mosi_d   = tx_q[bit_pos(tx_idx_q, lsb_q)];
        tx_idx_d = tx_idx_q + IDX_W'(1);
      end else begin
        rx_shift_d[bit_pos(rx_idx_q, lsb_q)] = miso;
        rx_idx_d = rx_idx_q + IDX_W'(1);
      end
    end else if (trail_edge) begin
      if (mode_q[0]) begin
        rx_shift_d[bit_pos(rx_idx_q, lsb_q)] = miso;
        rx_idx_d = rx_idx_q + IDX_W'(1);
      end else if (!last_edge) begin
        tx_idx_d = tx_idx_q + IDX_W'(1);
        mosi_d   = tx_q[bit_pos(tx_idx_q + IDX_W'(1), lsb_q)];
      end
    end
    if (state_d == IDLE) begin
      mosi_d = 1'b0;
    end

    if (state_d == IDLE) begin
      sclk_d = cpol;
    end else if (lead_edge || trail_edge) begin
      sclk_d = ~sclk_q;
    end else if (state_d == XFER) begin
      sclk_d = sclk_q;
    end else begin
      sclk_d = mode_d[1];
    end

    active_d  = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
    busy_d    = active_d;
    done_d    = (state_d == DONE);
    rx_data_d = (state_d == DONE) ? rx_shift_q : rx_data_q;
  end

  genvar gi;
  for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
    assign cs_n_d[gi] = !(active_d && (sel_d == CS_W'(gi)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      sel_q      <= '0;
      mode_q     <= MODE0;
      lsb_q      <= 1'b0;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      lsb_q      <= lsb_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/spi_master_cfg.md
SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 Parameters SHALL be:
  - DATA_W, default 8: bits per transfer, legal range 4..32.
  - NUM_CS, default 4: number of chip selects, legal range 1..8.
  - CLK_DIV, default 4: clk cycles per SCLK half-period, legal range 2..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk  in  1  single clock; all logic on its rising edge.
  - reset  in  1  asynchronous, active-low.
  - tx_enable  in  1  start request.
  - tx_data  in  DATA_W  word to transmit.
  - cs_sel  in  max(1,clog2(NUM_CS))  target slave.
  - cpol  in  1  clock polarity.
  - cpha  in  1  clock phase.
  - lsb_first  in  1  bit order; 1 = LSB first.
  - miso  in  1  serial data from slave.
  - sclk  out  1  serial clock.
  - mosi  out  1  serial data to slave.
  - cs_n  out  NUM_CS  active-low chip selects.
  - rx_data  out  DATA_W  last received word.
  - busy  out  1  transfer in progress.
  - done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have five states: IDLE, SETUP, XFER, HOLD, DONE.
REQ-004 IDLE -> SETUP SHALL occur when tx_enable=1 and cs_sel<NUM_CS; any other request SHALL be ignored with no output change.
REQ-005 On the start edge, the block SHALL latch tx_data, cs_sel, cpol, cpha and lsb_first; input changes after that edge SHALL have no effect on the transfer in progress.
REQ-006 The selected cs_n bit SHALL go low in the first SETUP cycle; all other cs_n bits SHALL stay high.
REQ-007 SETUP SHALL last CLK_DIV cycles.
REQ-008 XFER SHALL last 2*DATA_W*CLK_DIV cycles; SCLK SHALL toggle every CLK_DIV cycles, giving exactly 2*DATA_W edges.
REQ-009 HOLD SHALL last CLK_DIV cycles, with sclk at the latched cpol.
REQ-010 DONE SHALL last 1 cycle, then return to IDLE.
REQ-011 For cpha=0, the first bit SHALL be on mosi from the first SETUP cycle; miso SHALL be sampled on odd (leading) edges and mosi SHALL advance on even (trailing) edges, except after the final edge.
REQ-012 For cpha=1, mosi SHALL advance on leading edges (first bit driven at edge 1) and miso SHALL be sampled on trailing edges.
REQ-013 When lsb_first=1, bit order SHALL be LSB first for both transmit and receive; when lsb_first=0, MSB first.
REQ-014 In IDLE, sclk SHALL equal the live cpol input; in all other states it SHALL follow the latched cpol.
REQ-015 rx_data SHALL update only in the DONE cycle and hold its value otherwise.
REQ-016 done SHALL be high only in DONE; cs_n SHALL be all ones in DONE.
REQ-017 busy SHALL be high in SETUP, XFER and HOLD, and low in IDLE and DONE.
REQ-018 A tx_enable asserted in the DONE cycle SHALL be ignored; back-to-back transfers SHALL have a minimum gap of one IDLE cycle.
REQ-019 With tx_enable sampled at cycle 0, done SHALL be high at cycle 1+CLK_DIV*(2*DATA_W+2), i.e. cycle 73 for the defaults.
REQ-020 tx_enable while busy=1 SHALL be ignored, without queuing.
REQ-021 mosi SHALL be 0 in IDLE.

Reset
REQ-022 reset low SHALL take effect immediately, independent of clk, including mid-transfer.
REQ-023 Under reset: state=IDLE, cs_n all ones, sclk=0, mosi=0, rx_data=0, busy=0, done=0, and all counters cleared.
REQ-024 The first clk edge after reset is released SHALL be able to accept tx_enable.

Structure
REQ-025 A shared package spi_pkg SHALL hold:
  - the state enumeration;
  - the mode encoding {cpol,cpha} with MODE0..MODE3 constants;
  - default parameter constants.
REQ-026 A sub-module spi_clk_gen SHALL contain the CLK_DIV counter and the edge counter, and SHALL provide lead_edge, trail_edge and last_edge strobes to the FSM.
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 Mode 0, loopback (miso=mosi), tx_data=8'hA5, cs_sel=0 -> cs_n=4'b1110 during the transfer, done at cycle 73, rx_data=8'hA5.
REQ-029 Mode 3, lsb_first=1, slave model returning 8'h3C -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C; sclk idles high.
REQ-030 cs_sel=2 with tx_enable re-pulsed at cycle 20 -> cs_n=4'b1011, the second request ignored, exactly one done pulse.
REQ-031 reset low at cycle 30 of a transfer -> same-cycle cs_n=4'hF, busy=0, sclk=0; a new transfer after release completes normally.
REQ-032 DATA_W=16, CLK_DIV=2, mode 1, loopback 16'hBEEF -> 32 sclk edges, done at cycle 69, rx_data=16'hBEEF.
REQ-033 NUM_CS=3, cs_sel=3 -> request ignored, busy stays 0, cs_n stays 3'b111.
